// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI memory master.
// The state encoding and the command-bit values are the single source for the top and the bench.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        SETUP = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic CMD_WR = 1'b1;
    localparam logic CMD_RD = 1'b0;

    // Width of an index/counter spanning n values; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_en.sv
// SCLK generator: divides clk by CLK_DIV per half-period while enabled.
// It emits one-cycle strobes on the clk edge where sclk rises or falls.
module spi_clk_en
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
)
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic rise_en,
    output logic fall_en,
    output logic sclk
);

    localparam int CW = cnt_width(CLK_DIV);

    logic [CW-1:0] cnt_r;
    logic          sclk_r;
    logic          tick_s;

    // Half-period end detection; the sclk level decides which edge is next.
    always_comb begin
        tick_s  = en && (cnt_r == CW'(CLK_DIV - 1));
        rise_en = tick_s && !sclk_r;
        fall_en = tick_s && sclk_r;
    end

    // Divider counter and sclk level; both park at zero while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= '0;
            sclk_r <= 1'b0;
        end else if (!en) begin
            cnt_r  <= '0;
            sclk_r <= 1'b0;
        end else if (tick_s) begin
            cnt_r  <= '0;
            sclk_r <= ~sclk_r;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
        end
    end

    assign sclk = sclk_r;

endmodule

// File: rtl/spi_mem_master.sv
// Single-word SPI (mode 0, LSB first) write/read master for up to NUM_CS memory slaves.
// Frame = cmd bit, ADDR_W address bits, DATA_W data bits; out-of-range requests never touch the bus.
module spi_mem_master
    import spi_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 2,
    parameter int NUM_CS    = 1,
    parameter int MEM_DEPTH = 32
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          wr,
    input  logic [cnt_width(NUM_CS)-1:0]  cs_sel,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [DATA_W-1:0]             din,
    output logic [DATA_W-1:0]             dout,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic                          sclk,
    output logic                          mosi,
    input  logic                          miso,
    output logic [NUM_CS-1:0]             cs_n
);

    localparam int NBITS = 1 + ADDR_W + DATA_W;
    localparam int CSW   = cnt_width(NUM_CS);
    localparam int BCW   = $clog2(NBITS + 1);
    localparam int WCW   = cnt_width(CLK_DIV);

    state_t              state_r;
    state_t              state_s;
    logic                wr_r;
    logic [CSW-1:0]      sel_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   din_r;
    logic [NBITS-1:0]    tx_r;
    logic [DATA_W-1:0]   rx_r;
    logic [BCW-1:0]      bit_cnt_r;
    logic [WCW-1:0]      wait_r;
    logic [DATA_W-1:0]   dout_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;
    logic                mosi_r;
    logic [NUM_CS-1:0]   cs_n_r;

    logic                range_err_s;
    logic                wait_done_s;
    logic                frame_end_s;
    logic                shift_en_s;
    logic                rise_en_s;
    logic                fall_en_s;
    logic                sclk_s;

    spi_clk_en #(.CLK_DIV(CLK_DIV)) u_clk_en (
        .clk     (clk),
        .rst     (rst),
        .en      (shift_en_s),
        .rise_en (rise_en_s),
        .fall_en (fall_en_s),
        .sclk    (sclk_s)
    );

    // Range check on the latched request, plus timing qualifiers for the FSM.
    always_comb begin
        range_err_s = (32'(addr_r) >= 32'(MEM_DEPTH)) || (32'(sel_r) >= 32'(NUM_CS));
        wait_done_s = (wait_r == WCW'(CLK_DIV - 1));
        frame_end_s = fall_en_s && (bit_cnt_r == BCW'(NBITS));
        shift_en_s  = (state_r == SHIFT);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (start)       state_s = CHECK; else state_s = IDLE;
            CHECK:   if (range_err_s) state_s = DONE;  else state_s = SETUP;
            SETUP:   if (wait_done_s) state_s = SHIFT; else state_s = SETUP;
            SHIFT:   if (frame_end_s) state_s = HOLD;  else state_s = SHIFT;
            HOLD:    if (wait_done_s) state_s = DONE;  else state_s = HOLD;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register, request latches, shift datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            wr_r      <= 1'b0;
            sel_r     <= '0;
            addr_r    <= '0;
            din_r     <= '0;
            tx_r      <= '0;
            rx_r      <= '0;
            bit_cnt_r <= '0;
            wait_r    <= '0;
            dout_r    <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            mosi_r    <= 1'b0;
            cs_n_r    <= '1;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        wr_r   <= wr;
                        sel_r  <= cs_sel;
                        addr_r <= addr;
                        din_r  <= din;
                        err_r  <= 1'b0;
                    end
                end
                CHECK: begin
                    if (range_err_s) begin
                        err_r <= 1'b1;
                    end else begin
                        cs_n_r    <= ~(NUM_CS'(1) << sel_r);
                        tx_r      <= {(wr_r == CMD_WR) ? din_r : {DATA_W{1'b0}}, addr_r, wr_r};
                        mosi_r    <= wr_r;
                        wait_r    <= '0;
                        bit_cnt_r <= '0;
                    end
                end
                SETUP: begin
                    if (wait_done_s) wait_r <= '0;
                    else             wait_r <= wait_r + WCW'(1);
                end
                SHIFT: begin
                    if (rise_en_s) begin
                        rx_r              <= rx_r >> 1;
                        rx_r[DATA_W-1]    <= miso;
                        bit_cnt_r         <= bit_cnt_r + BCW'(1);
                    end
                    // After the last bit tx_r[1] is already zero, so mosi returns low.
                    if (fall_en_s) begin
                        tx_r   <= tx_r >> 1;
                        mosi_r <= tx_r[1];
                    end
                end
                HOLD: begin
                    if (wait_done_s) begin
                        wait_r <= '0;
                        cs_n_r <= '1;
                        if (wr_r == CMD_RD) dout_r <= rx_r;
                    end else begin
                        wait_r <= wait_r + WCW'(1);
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign dout = dout_r;
    assign busy = busy_r;
    assign done = done_r;
    assign err  = err_r;
    assign sclk = sclk_s;
    assign mosi = mosi_r;
    assign cs_n = cs_n_r;

endmodule

// File: tb/tb_spi_mem_master.sv
// Scoreboard bench for spi_mem_master: two configurations, each with a behavioural SPI memory
// per chip select; expected results are queued at issue and popped when done pulses.
module tb_spi_mem_master;

    localparam int LAT_A = 54;   // 8/16, CLK_DIV=1, NBITS=25: 2+1*(50+2)
    localparam int LAT_B = 146;  // 8/8,  CLK_DIV=4, NBITS=17: 2+4*(34+2)

    typedef struct packed {
        logic        err;
        logic [15:0] dout;
        logic [31:0] lat;
        logic [31:0] t0;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;
    int   cs0_lo_cnt;
    int   b_act_cnt;
    exp_t qa[$];
    exp_t qb[$];
    exp_t xa;
    exp_t xb;

    // DUT A: 8-bit address, 16-bit data, CLK_DIV 1, two slaves
    logic        start_a, wr_a, cs_sel_a, busy_a, done_a, err_a, sclk_a, mosi_a, miso_a;
    logic [7:0]  addr_a;
    logic [15:0] din_a, dout_a;
    logic [1:0]  cs_n_a;
    // DUT B: 8-bit address, 8-bit data, CLK_DIV 4, one slave
    logic        start_b, wr_b, cs_sel_b, busy_b, done_b, err_b, sclk_b, mosi_b, miso_b;
    logic [7:0]  addr_b, din_b, dout_b;
    logic [0:0]  cs_n_b;

    spi_mem_master #(.ADDR_W(8), .DATA_W(16), .CLK_DIV(1), .NUM_CS(2), .MEM_DEPTH(32)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .wr(wr_a), .cs_sel(cs_sel_a), .addr(addr_a),
        .din(din_a), .dout(dout_a), .busy(busy_a), .done(done_a), .err(err_a),
        .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a), .cs_n(cs_n_a));

    spi_mem_master #(.ADDR_W(8), .DATA_W(8), .CLK_DIV(4), .NUM_CS(1), .MEM_DEPTH(32)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .wr(wr_b), .cs_sel(cs_sel_b), .addr(addr_b),
        .din(din_b), .dout(dout_b), .busy(busy_b), .done(done_b), .err(err_b),
        .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .cs_n(cs_n_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) cs0_lo_cnt <= cs0_lo_cnt + ((cs_n_a[0] == 1'b0) ? 1 : 0);
    always @(negedge clk) b_act_cnt  <= b_act_cnt + ((cs_n_b != 1'b1 || sclk_b) ? 1 : 0);

    // ---------------- slave memory models ----------------
    logic [15:0] mem_a [2][32];
    logic [7:0]  mem_b [32];
    logic        sel_act_a, sel_act_b;
    int          cnt_a, cnt_b, who_a;
    logic [24:0] fr_a;
    logic [16:0] fr_b;

    assign sel_act_a = ~&cs_n_a;
    assign sel_act_b = ~cs_n_b[0];

    always @(posedge sel_act_a) begin
        cnt_a = 0; fr_a = '0; who_a = cs_n_a[0] ? 1 : 0;
    end
    always @(posedge sclk_a) if (sel_act_a && cnt_a < 25) begin fr_a[cnt_a] = mosi_a; cnt_a++; end
    always @(negedge sclk_a)
        if (sel_act_a && !fr_a[0] && cnt_a >= 9 && cnt_a < 25) miso_a = mem_a[who_a][fr_a[5:1]][cnt_a-9];
    always @(negedge sel_act_a) if (cnt_a == 25 && fr_a[0]) mem_a[who_a][fr_a[5:1]] = fr_a[24:9];

    always @(posedge sel_act_b) begin cnt_b = 0; fr_b = '0; end
    always @(posedge sclk_b) if (sel_act_b && cnt_b < 17) begin fr_b[cnt_b] = mosi_b; cnt_b++; end
    always @(negedge sclk_b)
        if (sel_act_b && !fr_b[0] && cnt_b >= 9 && cnt_b < 17) miso_b = mem_b[fr_b[5:1]][cnt_b-9];
    always @(negedge sel_act_b) if (cnt_b == 17 && fr_b[0]) mem_b[fr_b[5:1]] = fr_b[16:9];

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done_a) begin
            if (qa.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected_done: got done=1 expected no done at cycle %0d", cyc);
            end else begin
                xa = qa.pop_front();
                check("a_err", {31'd0, err_a}, {31'd0, xa.err});
                check("a_dout", {16'd0, dout_a}, {16'd0, xa.dout});
                check("a_latency", cyc - xa.t0 + 1, xa.lat);
                check("a_busy_at_done", {31'd0, busy_a}, 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done_b) begin
            if (qb.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected_done: got done=1 expected no done at cycle %0d", cyc);
            end else begin
                xb = qb.pop_front();
                check("b_err", {31'd0, err_b}, {31'd0, xb.err});
                check("b_dout", {24'd0, dout_b}, {16'd0, xb.dout});
                check("b_latency", cyc - xb.t0 + 1, xb.lat);
                check("b_busy_at_done", {31'd0, busy_b}, 32'd1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue_a(input logic w, input logic s, input logic [7:0] ad, input logic [15:0] d,
                           input logic e, input logic [15:0] xd, input int lat);
        exp_t x;
        @(negedge clk);
        start_a = 1'b1; wr_a = w; cs_sel_a = s; addr_a = ad; din_a = d;
        @(posedge clk); #1;
        x.err = e; x.dout = xd; x.lat = lat; x.t0 = cyc;
        qa.push_back(x);
        start_a = 1'b0; wr_a = ~w; cs_sel_a = ~s; addr_a = ~ad; din_a = ~d;
    endtask

    task automatic issue_b(input logic w, input logic [7:0] ad, input logic [7:0] d,
                           input logic e, input logic [7:0] xd, input int lat);
        exp_t x;
        @(negedge clk);
        start_b = 1'b1; wr_b = w; cs_sel_b = 1'b0; addr_b = ad; din_b = d;
        @(posedge clk); #1;
        x.err = e; x.dout = {8'd0, xd}; x.lat = lat; x.t0 = cyc;
        qb.push_back(x);
        start_b = 1'b0; wr_b = ~w; addr_b = ~ad; din_b = ~d;
    endtask

    task automatic drain_a;
        int n = 0;
        while (qa.size() != 0 && n < 400) begin @(negedge clk); n++; end
        if (qa.size() != 0) begin
            total++; bad++;
            $display("FAIL a_timeout: got %0d pending expected 0 after 400 cycles", qa.size());
            qa.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic drain_b;
        int n = 0;
        while (qb.size() != 0 && n < 400) begin @(negedge clk); n++; end
        if (qb.size() != 0) begin
            total++; bad++;
            $display("FAIL b_timeout: got %0d pending expected 0 after 400 cycles", qb.size());
            qb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        total = 0; bad = 0; cyc = 0; cs0_lo_cnt = 0; b_act_cnt = 0;
        miso_a = 1'b0; miso_b = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 32; j++) mem_a[i][j] = 16'h1000 + 16'(i * 256) + 16'(j);
        for (int j = 0; j < 32; j++) mem_b[j] = 8'h40 + 8'(j);
        rst = 1'b1;
        start_a = 1'b0; wr_a = 1'b0; cs_sel_a = 1'b0; addr_a = 8'd0; din_a = 16'd0;
        start_b = 1'b0; wr_b = 1'b0; cs_sel_b = 1'b0; addr_b = 8'd0; din_b = 8'd0;
        repeat (3) @(negedge clk);

        check("rst_a_cs_n", {30'd0, cs_n_a}, 32'h3);
        check("rst_a_outs", {27'd0, sclk_a, mosi_a, busy_a, done_a, err_a}, 32'd0);
        check("rst_a_dout", {16'd0, dout_a}, 32'd0);
        check("rst_b_cs_n", {31'd0, cs_n_b}, 32'h1);
        check("rst_b_outs", {27'd0, sclk_b, mosi_b, busy_b, done_b, err_b}, 32'd0);
        check("rst_b_dout", {24'd0, dout_b}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // write then read back addr 25 on the 8/8 CLK_DIV=4 instance
        issue_b(1'b1, 8'd25, 8'd25, 1'b0, 8'd0, LAT_B);  drain_b();
        check("b_mem25", {24'd0, mem_b[25]}, 32'd25);
        issue_b(1'b0, 8'd25, 8'd0, 1'b0, 8'd25, LAT_B);  drain_b();

        // out-of-range read: error after 2 cycles, no bus activity, err held, dout kept
        snap = b_act_cnt;
        issue_b(1'b0, 8'd40, 8'd0, 1'b1, 8'd25, 2);      drain_b();
        repeat (5) @(negedge clk);
        check("b_err_held", {31'd0, err_b}, 32'd1);
        check("b_err_no_bus", b_act_cnt - snap, 32'd0);
        issue_b(1'b1, 8'd7, 8'h3C, 1'b0, 8'd25, LAT_B);  drain_b();
        check("b_mem7", {24'd0, mem_b[7]}, 32'h3C);

        // 16-bit data to chip select 1, read back, cs 0 untouched
        snap = cs0_lo_cnt;
        issue_a(1'b1, 1'b1, 8'd3, 16'hA5C3, 1'b0, 16'h0000, LAT_A);  drain_a();
        issue_a(1'b0, 1'b1, 8'd3, 16'h0000, 1'b0, 16'hA5C3, LAT_A);  drain_a();
        check("a_cs0_never_low", cs0_lo_cnt - snap, 32'd0);
        check("a_mem1_3", {16'd0, mem_a[1][3]}, 32'hA5C3);
        check("a_mem0_3", {16'd0, mem_a[0][3]}, 32'h1003);

        // second start mid-SHIFT is ignored
        issue_a(1'b1, 1'b0, 8'd5, 16'h0F0F, 1'b0, 16'hA5C3, LAT_A);
        repeat (20) @(negedge clk);
        check("a_busy_mid", {31'd0, busy_a}, 32'd1);
        start_a = 1'b1; wr_a = 1'b1; cs_sel_a = 1'b0; addr_a = 8'd9; din_a = 16'hFFFF;
        repeat (2) @(negedge clk);
        start_a = 1'b0;
        drain_a();
        repeat (80) @(negedge clk);
        check("a_mem0_9_untouched", {16'd0, mem_a[0][9]}, 32'h1009);
        check("a_mem0_5", {16'd0, mem_a[0][5]}, 32'h0F0F);
        issue_a(1'b0, 1'b0, 8'd5, 16'h0000, 1'b0, 16'h0F0F, LAT_A);  drain_a();

        // reset in the middle of a frame, then a normal request
        issue_b(1'b1, 8'd10, 8'h77, 1'b0, 8'd25, LAT_B);
        repeat (40) @(negedge clk);
        check("b_busy_pre_rst", {31'd0, busy_b}, 32'd1);
        rst = 1'b1;
        #1;
        check("b_rst_cs_n", {31'd0, cs_n_b}, 32'h1);
        check("b_rst_sclk_busy", {30'd0, sclk_b, busy_b}, 32'd0);
        qb.delete();
        qa.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("b_mem10_unwritten", {24'd0, mem_b[10]}, 32'h4A);
        issue_b(1'b0, 8'd25, 8'd0, 1'b0, 8'd25, LAT_B);  drain_b();
        issue_b(1'b0, 8'd10, 8'd0, 1'b0, 8'h4A, LAT_B);  drain_b();

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
